led_array_ctrl: RTL and testbench

- Parametrised successor of the serial-addressed LED controller: a serial frame {mode, address} is shifted in, committed on a LATCH rising edge, and stored in a per-channel mode register.
- Fully synchronous to CLK; per-channel mode registers replace level-sensitive latches.
- Adds frame-length checking, commit acknowledge, out-of-range address rejection and an internal blink generator.
- Sits between the host serial pins and the LED output pins at top level.

---
 rtl/led_array_ctrl.sv | 140 ++++++++++++++
 tb/tb_led_array_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_array_ctrl.sv
// led_array_ctrl: serial {mode,addr} frames committed on LATCH edge into per-channel mode regs.
// Optional LED_BROADCAST_EN: all-ones address writes every channel at once.
module led_array_ctrl #(
  parameter int NUM_LEDS  = 25,
  parameter int ADDR_W    = 6,
  parameter int MODE_W    = 2,
  parameter int BLINK_DIV = 500000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                DATA,
  input  logic                SHIFT,
  input  logic                LATCH,
  input  logic                PATTERN,
  output logic [NUM_LEDS-1:0] LED,
  output logic                ACK,
  output logic                FRAME_ERR
);

  localparam int FRAME_W = MODE_W + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int DIV_W   = $clog2(BLINK_DIV);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  localparam logic [MODE_W-1:0] MODE_OFF   = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_ON    = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_BLINK = MODE_W'(2);
  localparam logic [MODE_W-1:0] MODE_PAT   = MODE_W'(3);

  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bitcnt;
  logic               latch_q;
  logic               commit;
  logic [MODE_W-1:0]  f_mode;
  logic [ADDR_W-1:0]  f_addr;
  logic               in_range;
  logic               is_bcast;
  logic               f_ok;
  logic               f_bad;
  logic               ok_q;
  logic               bad_q;
  logic [DIV_W-1:0]   presc;
  logic               blink_phase;
  logic [MODE_W-1:0]  mode_q [NUM_LEDS];

  assign commit   = LATCH & ~latch_q;
  assign f_mode   = shreg[FRAME_W-1 -: MODE_W];
  assign f_addr   = shreg[ADDR_W-1:0];
  assign in_range = int'(f_addr) < NUM_LEDS;

`ifdef LED_BROADCAST_EN
  assign is_bcast = &f_addr;
`else
  assign is_bcast = 1'b0;
`endif

  // Frame checked against contents before this cycle's shift
  assign f_ok  = commit & (bitcnt == CNT_FULL)
               & (in_range | is_bcast);
  assign f_bad = commit & ~f_ok;

  // Serial shift register, bit counter and LATCH edge history
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg   <= '0;
      bitcnt  <= '0;
      latch_q <= 1'b0;
    end else begin
      latch_q <= LATCH;
      if (SHIFT)
        shreg <= {shreg[FRAME_W-2:0], DATA};
      if (commit)
        bitcnt <= {{(CNT_W-1){1'b0}}, SHIFT};
      else if (SHIFT && bitcnt != CNT_SAT)
        bitcnt <= bitcnt + CNT_W'(1);
    end
  end

  // Per-channel mode registers written by accepted frames
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_LEDS; i++)
        mode_q[i] <= MODE_OFF;
    end else if (f_ok) begin
      for (int i = 0; i < NUM_LEDS; i++)
        if (is_bcast || f_addr == ADDR_W'(i))
          mode_q[i] <= f_mode;
    end
  end

  // Commit result held one cycle so ACK lines up with the LED change
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ok_q      <= 1'b0;
      bad_q     <= 1'b0;
      ACK       <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      ok_q  <= f_ok;
      bad_q <= f_bad;
      ACK   <= ok_q;
      if (bad_q)
        FRAME_ERR <= 1'b1;
      else if (ok_q)
        FRAME_ERR <= 1'b0;
    end
  end

  // Free-running blink prescaler with shared phase
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc       <= '0;
      blink_phase <= 1'b0;
    end else if (presc == DIV_LAST) begin
      presc       <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end

  // Registered LED drive selected by each channel's mode
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LED <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        unique case (mode_q[i])
          MODE_OFF:   LED[i] <= 1'b0;
          MODE_ON:    LED[i] <= 1'b1;
          MODE_BLINK: LED[i] <= blink_phase;
          MODE_PAT:   LED[i] <= PATTERN;
        endcase
    end
  end

endmodule

// File: tb/tb_led_array_ctrl.sv
// tb_led_array_ctrl: scoreboard bench for led_array_ctrl.
// Stimulus queues expected per-cycle state; a negedge monitor compares.
module tb_led_array_ctrl;

  localparam int N = 25;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         DATA = 1'b0;
  logic         SHIFT = 1'b0;
  logic         LATCH = 1'b0;
  logic         PATTERN = 1'b0;
  logic [N-1:0] LED;
  logic         ACK;
  logic         FRAME_ERR;

  led_array_ctrl #(
    .NUM_LEDS (N),
    .ADDR_W   (6),
    .MODE_W   (2),
    .BLINK_DIV(4)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .DATA     (DATA),
    .SHIFT    (SHIFT),
    .LATCH    (LATCH),
    .PATTERN  (PATTERN),
    .LED      (LED),
    .ACK      (ACK),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] mask;
    logic [N-1:0] led;
    logic         ack;
    logic         err;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   mode_m[N];
  logic err_m = 1'b0;
  int   rel = 0;

  function automatic logic [N-1:0] model_led(int c);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      case (mode_m[i])
        1: v[i] = 1'b1;
        2: v[i] = (((c - 1 - rel) / 4) % 2) == 1;
        default: v[i] = 1'b0;
      endcase
    return v;
  endfunction

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    m = '1;
    for (int i = 0; i < N; i++)
      if (mode_m[i] == 3) m[i] = 1'b0;
    return m;
  endfunction

  task automatic expect_at(int c, logic ack, string name);
    exp_t e;
    e.cyc  = c;
    e.mask = model_mask();
    e.led  = model_led(c);
    e.ack  = ack;
    e.err  = err_m;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic shift_bits(logic [7:0] f, int n);
    for (int i = 0; i < n; i++) begin
      DATA  = f[7-i];
      SHIFT = 1'b1;
      tick();
    end
    SHIFT = 1'b0;
    DATA  = 1'b0;
  endtask

  task automatic apply(logic [7:0] f, logic ok, logic bc);
    if (ok) begin
      err_m = 1'b0;
      for (int i = 0; i < N; i++)
        if (bc || i == int'(f[5:0])) mode_m[i] = int'(f[7:6]);
    end else begin
      err_m = 1'b1;
    end
  endtask

  task automatic send(logic [7:0] f, int nb, logic ok,
                      logic bc, string name);
    int k;
    shift_bits(f, nb);
    LATCH = 1'b1;
    k = cyc;
    apply(f, ok, bc);
    expect_at(k + 2, ok, name);
    expect_at(k + 3, 1'b0, {name, "_after"});
    tick();
    LATCH = 1'b0;
    tick(3);
  endtask

  task automatic span(int n, string name);
    int c0;
    c0 = cyc;
    for (int j = 1; j <= n; j++)
      expect_at(c0 + j, 1'b0, name);
    tick(n);
  endtask

  task automatic pat_step(logic p);
    exp_t e;
    PATTERN = p;
    e.cyc  = cyc + 1;
    e.mask = '0;
    e.mask[6] = 1'b1;
    e.led  = '0;
    e.led[6] = p;
    e.ack  = 1'b0;
    e.err  = err_m;
    e.name = "pattern_follow";
    sbq.push_back(e);
    tick();
  endtask

  // Scoreboard monitor
  exp_t e_m;
  bit   ack_exp;
  always @(negedge CLK) begin
    ack_exp = 1'b0;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e_m = sbq.pop_front();
      checks++;
      if (e_m.cyc < cyc) begin
        failures++;
        $display("FAIL %s stale entry cyc=%0d now=%0d",
                 e_m.name, e_m.cyc, cyc);
      end else begin
        if (e_m.ack) ack_exp = 1'b1;
        if ((LED & e_m.mask) !== (e_m.led & e_m.mask) ||
            ACK !== e_m.ack || FRAME_ERR !== e_m.err) begin
          failures++;
          $display("FAIL %s cyc=%0d got led=%h ack=%b err=%b want led=%h ack=%b err=%b mask=%h",
                   e_m.name, cyc, LED, ACK, FRAME_ERR,
                   e_m.led, e_m.ack, e_m.err, e_m.mask);
        end
      end
    end
    if (ACK === 1'b1 && !ack_exp) begin
      checks++;
      failures++;
      $display("FAIL ack_unexpected cyc=%0d got ack=1 want 0", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] fb;
    for (int i = 0; i < N; i++) mode_m[i] = 0;
    tick(3);
    expect_at(cyc, 1'b0, "reset_state");
    tick();
    RESET = 1'b0;
    rel = cyc;
    tick(2);

    send(8'b01_000011, 8, 1'b1, 1'b0, "led3_on");
    send(8'b01_000011, 7, 1'b0, 1'b0, "short_frame");
    send(8'b01_000000, 8, 1'b1, 1'b0, "led0_on");
    send(8'b01_011001, 8, 1'b0, 1'b0, "addr25_reject");
`ifdef LED_BROADCAST_EN
    send(8'b10_111111, 8, 1'b1, 1'b1, "bcast_blink");
`else
    send(8'b10_111111, 8, 1'b0, 1'b0, "bcast_reject");
`endif

    send(8'b10_000101, 8, 1'b1, 1'b0, "led5_blink");
    span(12, "blink_track");

    send(8'b11_000110, 8, 1'b1, 1'b0, "led6_pattern");
    pat_step(1'b1);
    pat_step(1'b0);
    pat_step(1'b1);
    pat_step(1'b0);
    tick(2);

    shift_bits(8'b01_000001, 8);
    LATCH = 1'b1;
    k = cyc;
    apply(8'b01_000001, 1'b1, 1'b0);
    expect_at(k + 2, 1'b1, "hold_ack");
    for (int j = 3; j <= 11; j++)
      expect_at(k + j, 1'b0, "hold_no_reack");
    tick(10);
    LATCH = 1'b0;
    tick();

    fb = 8'b01_000100;
    shift_bits(8'b01_000010, 8);
    LATCH = 1'b1;
    SHIFT = 1'b1;
    DATA  = fb[7];
    k = cyc;
    apply(8'b01_000010, 1'b1, 1'b0);
    expect_at(k + 2, 1'b1, "commit_with_shift");
    expect_at(k + 3, 1'b0, "commit_with_shift_after");
    tick();
    LATCH = 1'b0;
    for (int i = 1; i < 8; i++) begin
      DATA  = fb[7-i];
      SHIFT = 1'b1;
      tick();
    end
    SHIFT = 1'b0;
    send(fb, 0, 1'b1, 1'b0, "second_frame");

    shift_bits(8'b01_000111, 4);
    RESET = 1'b1;
    for (int i = 0; i < N; i++) mode_m[i] = 0;
    err_m = 1'b0;
    expect_at(cyc, 1'b0, "async_reset");
    tick(2);
    RESET = 1'b0;
    rel = cyc;
    tick();
    send(8'b01_010000, 8, 1'b1, 1'b0, "post_reset");

    tick(5);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL leftover got %0d want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
